sram_port_arbiter: RTL

SRAM_PORT_ARBITER -- requirements
Module: sram_port_arbiter

---
 rtl/sram_port_arbiter_pkg.sv | 7 +
 rtl/rr_arb2.sv | 24 ++
 rtl/sram_port_arbiter.sv | 107 ++++++++++
 3 files changed

// File: rtl/sram_port_arbiter_pkg.sv
// sram_port_arbiter_pkg: shared FSM/requester enums and width defaults for the SRAM port arbiter
package sram_port_arbiter_pkg;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 4;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;
  typedef enum logic {REQ_A, REQ_B} req_e;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-input round-robin grant with last-grant pointer (ports: clk/rst, requests, enable, grants, winner id)
module rr_arb2
  import sram_port_arbiter_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic req_a_i,
  input  logic req_b_i,
  input  logic en_i,
  output logic gnt_a_o,
  output logic gnt_b_o,
  output req_e win_o
);
  req_e last_q, last_d;
  // on a tie the requester not granted last wins; reset points at B so A wins first
  assign win_o = (req_a_i && req_b_i) ? ((last_q == REQ_A) ? REQ_B : REQ_A)
                                      : (req_a_i ? REQ_A : REQ_B);
  assign gnt_a_o = en_i && req_a_i && (win_o == REQ_A);
  assign gnt_b_o = en_i && req_b_i && (win_o == REQ_B);
  assign last_d = (gnt_a_o || gnt_b_o) ? win_o : last_q;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) last_q <= REQ_B;
    else last_q <= last_d;
endmodule

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: round-robin arbiter sharing one single-port SRAM between fetch (A, read) and loader (B, read/write)
module sram_port_arbiter
  import sram_port_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk0,
  input  logic                  rstb0,
  input  logic                  a_valid,
  output logic                  a_ready,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  output logic                  a_rvalid,
  input  logic                  a_rready,
  input  logic                  b_valid,
  output logic                  b_ready,
  input  logic                  b_we,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic                  b_rvalid,
  input  logic                  b_rready,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  csb0,
  output logic                  web0,
  output logic [ADDR_WIDTH-1:0] addr0,
  output logic [DATA_WIDTH-1:0] din0,
  input  logic [DATA_WIDTH-1:0] dout0
);
  state_e state_q, state_d;
  req_e gid_q, gid_d, win;
  logic wr_q, wr_d, gnt_a, gnt_b;
  logic csb0_q, csb0_d, web0_q, web0_d;
  logic [ADDR_WIDTH-1:0] addr0_q, addr0_d;
  logic [DATA_WIDTH-1:0] din0_q, din0_d, rdata_q, rdata_d;
  rr_arb2 u_arb (
    .clk_i  (clk0),
    .rst_ni (rstb0),
    .req_a_i(a_valid),
    .req_b_i(b_valid),
    .en_i   (state_q == IDLE),
    .gnt_a_o(gnt_a),
    .gnt_b_o(gnt_b),
    .win_o  (win)
  );
  assign a_ready  = gnt_a;
  assign b_ready  = gnt_b;
  assign a_rvalid = (state_q == RESP) && (gid_q == REQ_A);
  assign b_rvalid = (state_q == RESP) && (gid_q == REQ_B);
  assign rdata    = rdata_q;
  assign csb0     = csb0_q;
  assign web0     = web0_q;
  assign addr0    = addr0_q;
  assign din0     = din0_q;
  always_comb begin
    state_d = state_q;
    gid_d   = gid_q;
    wr_d    = wr_q;
    csb0_d  = csb0_q;
    web0_d  = web0_q;
    addr0_d = addr0_q;
    din0_d  = din0_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: if (gnt_a || gnt_b) begin
        state_d = ISSUE;
        gid_d   = win;
        wr_d    = (win == REQ_B) && b_we;
        csb0_d  = 1'b0;
        web0_d  = ~wr_d;
        addr0_d = (win == REQ_B) ? b_addr : a_addr;
        din0_d  = wr_d ? b_wdata : din0_q;
      end
      ISSUE: begin
        state_d = WAIT;
        csb0_d  = 1'b1;
        web0_d  = 1'b1;
      end
      // macro drives dout0 after the falling edge following its sampling edge
      WAIT: begin
        state_d = RESP;
        rdata_d = wr_q ? rdata_q : dout0;
      end
      RESP: if ((gid_q == REQ_A) ? a_rready : b_rready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk0 or negedge rstb0)
    if (!rstb0) begin
      state_q <= IDLE;
      gid_q   <= REQ_A;
      wr_q    <= 1'b0;
      csb0_q  <= 1'b1;
      web0_q  <= 1'b1;
      addr0_q <= '0;
      din0_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      gid_q   <= gid_d;
      wr_q    <= wr_d;
      csb0_q  <= csb0_d;
      web0_q  <= web0_d;
      addr0_q <= addr0_d;
      din0_q  <= din0_d;
      rdata_q <= rdata_d;
    end
endmodule
